// File: rtl/load_store_unit_pkg.sv
// Shared types for the load/store unit: memory-op codes, FSM states, store lane bundle.
// No logic; helpers classify op codes.
// Imported by load_store_unit, lsu_align and the bench.
package load_store_unit_pkg;

    typedef enum logic [3:0] {
        DMEM_NO  = 4'd0,
        DMEM_LB  = 4'd1,
        DMEM_LH  = 4'd2,
        DMEM_LW  = 4'd3,
        DMEM_LBU = 4'd4,
        DMEM_LHU = 4'd5,
        DMEM_SB  = 4'd6,
        DMEM_SH  = 4'd7,
        DMEM_SW  = 4'd8
    } dmem_type_e;

    typedef enum logic [1:0] {
        LSU_IDLE = 2'd0,
        LSU_REQ  = 2'd1,
        LSU_WAIT = 2'd2,
        LSU_DONE = 2'd3
    } lsu_state_e;

    typedef struct packed {
        logic [3:0]  be;
        logic [31:0] wdata;
    } store_lane_t;

    function automatic logic is_valid_type(input logic [3:0] t);
        return (t >= 4'd1) && (t <= 4'd8);
    endfunction

    function automatic logic is_store(input logic [3:0] t);
        return (t == DMEM_SB) || (t == DMEM_SH) || (t == DMEM_SW);
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Alignment check, store lane steering and load extract/extend.
// Purely combinational, zero latency.
// No flow control; callers register the results.
module lsu_align
    import load_store_unit_pkg::*;
(
    input  logic [3:0]  req_type,
    input  logic [1:0]  req_offset,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  ld_type,
    input  logic [1:0]  ld_offset,
    input  logic [31:0] ld_rdata,
    output logic        misaligned,
    output store_lane_t lane,
    output logic [31:0] ld_data
);

    logic [31:0] shifted;

    always_comb begin
        misaligned = 1'b0;
        lane       = '0;
        case (req_type)
            DMEM_LB, DMEM_LBU: lane.be = 4'b0001 << req_offset;
            DMEM_SB: begin
                lane.be    = 4'b0001 << req_offset;
                lane.wdata = {4{req_wdata[7:0]}};
            end
            DMEM_LH, DMEM_LHU: begin
                misaligned = req_offset[0];
                lane.be    = 4'b0011 << req_offset;
            end
            DMEM_SH: begin
                misaligned = req_offset[0];
                lane.be    = 4'b0011 << req_offset;
                lane.wdata = {2{req_wdata[15:0]}};
            end
            DMEM_LW: begin
                misaligned = |req_offset;
                lane.be    = 4'b1111;
            end
            DMEM_SW: begin
                misaligned = |req_offset;
                lane.be    = 4'b1111;
                lane.wdata = req_wdata;
            end
            default: ;
        endcase
    end

    // Addressed byte/halfword lands in the low lanes before extension.
    assign shifted = ld_rdata >> {ld_offset, 3'b000};

    always_comb begin
        ld_data = '0;
        case (ld_type)
            DMEM_LB:  ld_data = {{24{shifted[7]}}, shifted[7:0]};
            DMEM_LBU: ld_data = {24'd0, shifted[7:0]};
            DMEM_LH:  ld_data = {{16{shifted[15]}}, shifted[15:0]};
            DMEM_LHU: ld_data = {16'd0, shifted[15:0]};
            DMEM_LW:  ld_data = shifted;
            default:  ld_data = '0;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Memory-stage load/store unit: one op at a time over a req/gnt/rvalid data bus.
// Latency: store 2, load 3 (rvalid one cycle after gnt), misaligned 1 cycle.
// Accepts only in IDLE (req_ready_o); bus stalls on gnt/rvalid hold the FSM.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic [3:0]        dmem_type_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [31:0]       wdata_i,
    input  logic              kill_i,
    output logic              rsp_valid_o,
    output logic [31:0]       rdata_o,
    output logic              misaligned_o,
    output logic              bus_req_o,
    output logic              bus_we_o,
    output logic [ADDR_W-1:0] bus_addr_o,
    output logic [3:0]        bus_be_o,
    output logic [31:0]       bus_wdata_o,
    input  logic              bus_gnt_i,
    input  logic              bus_rvalid_i,
    input  logic [31:0]       bus_rdata_i
);

    lsu_state_e        state_q, state_d;
    logic [3:0]        type_q;
    logic [ADDR_W-1:0] addr_q;
    store_lane_t       lane_q;
    logic              mis_q;
    logic              kill_q;
    logic [31:0]       rdata_q;

    logic              req_misaligned;
    store_lane_t       req_lane;
    logic [31:0]       ld_data;
    logic              accept;

    lsu_align u_align (
        .req_type   (dmem_type_i),
        .req_offset (addr_i[1:0]),
        .req_wdata  (wdata_i),
        .ld_type    (type_q),
        .ld_offset  (addr_q[1:0]),
        .ld_rdata   (bus_rdata_i),
        .misaligned (req_misaligned),
        .lane       (req_lane),
        .ld_data    (ld_data)
    );

    assign accept = (state_q == LSU_IDLE) && req_valid_i && is_valid_type(dmem_type_i);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= LSU_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        req_ready_o  = 1'b0;
        bus_req_o    = 1'b0;
        bus_we_o     = 1'b0;
        bus_addr_o   = '0;
        bus_be_o     = '0;
        bus_wdata_o  = '0;
        rsp_valid_o  = 1'b0;
        rdata_o      = '0;
        misaligned_o = 1'b0;
        unique case (state_q)
            LSU_IDLE: begin
                req_ready_o = 1'b1;
                if (accept) begin
                    state_d = req_misaligned ? LSU_DONE : LSU_REQ;
                end
            end
            LSU_REQ: begin
                bus_req_o   = 1'b1;
                bus_we_o    = is_store(type_q);
                bus_addr_o  = {addr_q[ADDR_W-1:2], 2'b00};
                bus_be_o    = lane_q.be;
                bus_wdata_o = lane_q.wdata;
                // A grant in the kill cycle wins: the transfer is already committed.
                if (bus_gnt_i) begin
                    state_d = is_store(type_q) ? LSU_DONE : LSU_WAIT;
                end else if (kill_i) begin
                    state_d = LSU_IDLE;
                end
            end
            LSU_WAIT: begin
                if (bus_rvalid_i) begin
                    state_d = LSU_DONE;
                end
            end
            LSU_DONE: begin
                state_d = LSU_IDLE;
                if (!kill_q && !kill_i) begin
                    rsp_valid_o  = 1'b1;
                    rdata_o      = rdata_q;
                    misaligned_o = mis_q;
                end
            end
            default: state_d = LSU_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            type_q  <= '0;
            addr_q  <= '0;
            lane_q  <= '0;
            mis_q   <= 1'b0;
            kill_q  <= 1'b0;
            rdata_q <= '0;
        end else begin
            if (accept) begin
                type_q  <= dmem_type_i;
                addr_q  <= addr_i;
                lane_q  <= req_lane;
                mis_q   <= req_misaligned;
                kill_q  <= 1'b0;
                rdata_q <= '0;
            end
            if (state_q == LSU_REQ && bus_gnt_i && kill_i) begin
                kill_q <= 1'b1;
            end
            if (state_q == LSU_WAIT) begin
                if (kill_i) begin
                    kill_q <= 1'b1;
                end
                if (bus_rvalid_i) begin
                    rdata_q <= ld_data;
                end
            end
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: directed cases plus random ops against a byte-level model.
module tb_load_store_unit;
    import load_store_unit_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        req_valid_i;
    logic        req_ready_o;
    logic [3:0]  dmem_type_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic        kill_i;
    logic        rsp_valid_o;
    logic [31:0] rdata_o;
    logic        misaligned_o;
    logic        bus_req_o;
    logic        bus_we_o;
    logic [31:0] bus_addr_o;
    logic [3:0]  bus_be_o;
    logic [31:0] bus_wdata_o;
    logic        bus_gnt_i;
    logic        bus_rvalid_i;
    logic [31:0] bus_rdata_i;

    always #5 clk_i = ~clk_i;

    load_store_unit #(.ADDR_W(32)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .dmem_type_i(dmem_type_i), .addr_i(addr_i), .wdata_i(wdata_i), .kill_i(kill_i),
        .rsp_valid_o(rsp_valid_o), .rdata_o(rdata_o), .misaligned_o(misaligned_o),
        .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o),
        .bus_be_o(bus_be_o), .bus_wdata_o(bus_wdata_o),
        .bus_gnt_i(bus_gnt_i), .bus_rvalid_i(bus_rvalid_i), .bus_rdata_i(bus_rdata_i)
    );

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
    } bus_exp_t;

    typedef struct {
        logic        mis;
        logic [31:0] rdata;
    } rsp_exp_t;

    bus_exp_t    bus_q[$];
    rsp_exp_t    rsp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          gnt_dly = 0;
    int          rv_dly = 0;
    logic [31:0] cur_rdata = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int op_size(input logic [3:0] t);
        case (t)
            DMEM_LB, DMEM_LBU, DMEM_SB: return 1;
            DMEM_LH, DMEM_LHU, DMEM_SH: return 2;
            DMEM_LW, DMEM_SW:           return 4;
            default:                    return 0;
        endcase
    endfunction

    function automatic bit op_is_store(input logic [3:0] t);
        return (t == DMEM_SB) || (t == DMEM_SH) || (t == DMEM_SW);
    endfunction

    function automatic logic [31:0] model_load(input logic [3:0] t, input logic [31:0] addr,
                                               input logic [31:0] word);
        int     size;
        longint span;
        longint v;
        size = op_size(t);
        span = longint'(1) << (8 * size);
        v    = longint'(word >> (8 * (addr % 4))) % span;
        if ((t == DMEM_LB || t == DMEM_LH) && v >= span / 2) v = v - span;
        return 32'(v);
    endfunction

    function automatic logic [31:0] model_wdata(input logic [3:0] t, input logic [31:0] wdata);
        logic [31:0] rep;
        int          size;
        size = op_size(t);
        rep  = '0;
        for (int i = 0; i < 4; i++) rep[8*i +: 8] = wdata[8*(i % size) +: 8];
        return rep;
    endfunction

    // ---------------- bus responder ----------------
    int gcnt = 0;
    int rcnt = 0;
    bit pend = 0;

    initial begin
        bus_gnt_i    = 1'b0;
        bus_rvalid_i = 1'b0;
        bus_rdata_i  = '0;
        forever begin
            @(negedge clk_i);
            bus_gnt_i    = 1'b0;
            bus_rvalid_i = 1'b0;
            bus_rdata_i  = $urandom;
            if (rst_i) begin
                pend = 0;
                gcnt = 0;
            end else begin
                if (pend) begin
                    if (rcnt >= rv_dly) begin
                        bus_rvalid_i = 1'b1;
                        bus_rdata_i  = cur_rdata;
                        pend         = 0;
                    end else begin
                        rcnt++;
                    end
                end
                if (bus_req_o) begin
                    if (gcnt >= gnt_dly) begin
                        bus_gnt_i = 1'b1;
                        gcnt      = 0;
                        if (!bus_we_o) begin
                            pend = 1;
                            rcnt = 0;
                        end
                    end else begin
                        gcnt++;
                    end
                end else begin
                    gcnt = 0;
                end
            end
        end
    end

    // ---------------- monitor ----------------
    logic        prev_stall = 1'b0;
    logic [31:0] prev_addr;
    logic [3:0]  prev_be;
    logic [31:0] prev_wdata;
    bus_exp_t    be_exp;
    rsp_exp_t    rs_exp;

    initial begin
        forever begin
            @(negedge clk_i);
            #1;
            if (bus_req_o) begin
                if (prev_stall) begin
                    check("stall_addr", bus_addr_o, prev_addr);
                    check("stall_be", 32'(bus_be_o), 32'(prev_be));
                    check("stall_wdata", bus_wdata_o, prev_wdata);
                end
                if (bus_gnt_i) begin
                    prev_stall = 1'b0;
                    if (bus_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_bus: got addr %h be %h, required no transfer", bus_addr_o, bus_be_o);
                    end else begin
                        be_exp = bus_q.pop_front();
                        check("bus_addr", bus_addr_o, be_exp.addr);
                        check("bus_we", 32'(bus_we_o), 32'(be_exp.we));
                        check("bus_be", 32'(bus_be_o), 32'(be_exp.be));
                        if (be_exp.we) check("bus_wdata", bus_wdata_o, be_exp.wdata);
                    end
                end else begin
                    prev_stall = 1'b1;
                    prev_addr  = bus_addr_o;
                    prev_be    = bus_be_o;
                    prev_wdata = bus_wdata_o;
                end
            end else begin
                prev_stall = 1'b0;
            end
            if (rsp_valid_o) begin
                if (rsp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_rsp: got rdata %h mis %b, required no response", rdata_o, misaligned_o);
                end else begin
                    rs_exp = rsp_q.pop_front();
                    check("rsp_mis", 32'(misaligned_o), 32'(rs_exp.mis));
                    check("rsp_rdata", rdata_o, rs_exp.rdata);
                end
            end else begin
                check("idle_rdata", rdata_o, 32'h0);
                check("idle_mis", 32'(misaligned_o), 32'h0);
            end
        end
    end

    // ---------------- driver ----------------
    // kill_mode: 0 none, 1 kill before grant, 2 kill with grant, 3 kill in WAIT,
    //            4 kill in DONE, 5 reset in WAIT
    task automatic do_op(input logic [3:0] t, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] rword, input int gd, input int rd,
                         input int kill_mode, input int exp_lat);
        int       size;
        bit       valid;
        bit       mis;
        int       seen;
        bit       fin;
        bus_exp_t b;
        rsp_exp_t r;
        size      = op_size(t);
        valid     = (size != 0);
        mis       = valid && ((addr % size) != 0);
        gnt_dly   = gd;
        rv_dly    = rd;
        cur_rdata = rword;
        if (valid && !mis && kill_mode != 1) begin
            b.addr  = addr & 32'hFFFF_FFFC;
            b.we    = op_is_store(t);
            b.be    = 4'(((1 << size) - 1) << (addr % 4));
            b.wdata = op_is_store(t) ? model_wdata(t, wdata) : 32'h0;
            bus_q.push_back(b);
        end
        if (valid && kill_mode == 0) begin
            r.mis   = mis;
            r.rdata = (mis || op_is_store(t)) ? 32'h0 : model_load(t, addr, rword);
            rsp_q.push_back(r);
        end
        @(negedge clk_i);
        req_valid_i = 1'b1;
        dmem_type_i = t;
        addr_i      = addr;
        wdata_i     = wdata;
        @(negedge clk_i);
        req_valid_i = 1'b0;
        seen = -1;
        fin  = 0;
        for (int c = 1; c <= 60; c++) begin
            kill_i = ((kill_mode == 1 || kill_mode == 2) && c == 1) ||
                     ((kill_mode == 3 || kill_mode == 4) && c == 2);
            if (kill_mode == 5 && c == 2) rst_i = 1'b1;
            #1;
            if (kill_mode == 5 && c == 2) begin
                check("rst_ready", 32'(req_ready_o), 32'h1);
                check("rst_bus_req", 32'(bus_req_o), 32'h0);
                check("rst_rsp", 32'(rsp_valid_o), 32'h0);
            end
            if (rsp_valid_o && seen < 0) seen = c;
            if (req_ready_o) begin
                fin = 1;
                break;
            end
            @(negedge clk_i);
        end
        kill_i = 1'b0;
        if (!fin) begin
            checks++;
            errors++;
            $display("FAIL timeout: op %h addr %h never returned to ready", t, addr);
        end
        if (exp_lat >= 0) check("latency", 32'(seen), 32'(exp_lat));
        if (kill_mode != 0 || !valid) check("no_rsp", 32'(seen), 32'hFFFF_FFFF);
        if (rst_i) begin
            @(negedge clk_i);
            @(negedge clk_i);
            rst_i = 1'b0;
        end
    endtask

    initial begin
        logic [3:0] rt;
        rst_i       = 1'b1;
        req_valid_i = 1'b0;
        dmem_type_i = '0;
        addr_i      = '0;
        wdata_i     = '0;
        kill_i      = 1'b0;
        repeat (2) @(negedge clk_i);
        #1;
        check("reset_ready", 32'(req_ready_o), 32'h1);
        check("reset_bus_req", 32'(bus_req_o), 32'h0);
        check("reset_bus_addr", bus_addr_o, 32'h0);
        check("reset_be", 32'(bus_be_o), 32'h0);
        check("reset_rsp", 32'(rsp_valid_o), 32'h0);
        @(negedge clk_i);
        rst_i = 1'b0;

        do_op(DMEM_SB,  32'h1003, 32'h1234_56AB, 32'h0,         0, 0, 0, 2);
        do_op(DMEM_LB,  32'h2001, 32'h0,         32'h0000_80FF, 0, 0, 0, 3);
        do_op(DMEM_LBU, 32'h2001, 32'h0,         32'h0000_80FF, 0, 0, 0, 3);
        do_op(DMEM_LH,  32'h2002, 32'h0,         32'h7FFF_0000, 0, 0, 0, 3);
        do_op(DMEM_LW,  32'h2004, 32'h0,         32'hDEAD_BEEF, 0, 0, 0, 3);
        do_op(DMEM_LHU, 32'h2002, 32'h0,         32'h8001_0000, 0, 1, 0, 4);
        do_op(DMEM_SH,  32'h2006, 32'hAAAA_5A3C, 32'h0,         0, 0, 0, 2);
        do_op(DMEM_LW,  32'h3002, 32'h0,         32'h0,         0, 0, 0, 1);
        do_op(DMEM_SH,  32'h3001, 32'h0000_1111, 32'h0,         0, 0, 0, 1);
        do_op(DMEM_SW,  32'h4000, 32'hCAFE_F00D, 32'h0,         3, 0, 0, 5);
        do_op(DMEM_LW,  32'h5000, 32'h0,         32'h1111_2222, 8, 0, 1, -1);
        do_op(DMEM_LH,  32'h5002, 32'h0,         32'h3333_4444, 0, 0, 2, -1);
        do_op(DMEM_LW,  32'h5004, 32'h0,         32'h5555_6666, 0, 3, 3, -1);
        do_op(DMEM_SB,  32'h5005, 32'h0000_0077, 32'h0,         0, 0, 4, -1);
        do_op(DMEM_LW,  32'h6000, 32'h0,         32'h7777_8888, 0, 5, 5, -1);
        do_op(DMEM_SW,  32'h6004, 32'h0102_0304, 32'h0,         0, 0, 0, 2);
        do_op(DMEM_NO,  32'h7000, 32'hFFFF_FFFF, 32'h0,         0, 0, 0, -1);
        do_op(4'd12,    32'h7004, 32'hFFFF_FFFF, 32'h0,         0, 0, 0, -1);

        for (int n = 0; n < 250; n++) begin
            rt = 4'($urandom_range(0, 9));
            do_op(rt, $urandom, $urandom, $urandom,
                  $urandom_range(0, 3), $urandom_range(0, 3), 0, -1);
        end

        repeat (5) @(negedge clk_i);
        check("bus_queue_empty", 32'(bus_q.size()), 32'h0);
        check("rsp_queue_empty", 32'(rsp_q.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
